alu_seq_n: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_seq_n_if.sv | 21 ++
 rtl/seq_divider_n.sv | 35 +++
 rtl/alu_seq_n.sv | 147 ++++++++++++++
 tb/tb_alu_seq_n.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and flag bit indices shared by the sequential ALU.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_REM = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;
    localparam int FLAG_Z  = 3;
    localparam int FLAG_N  = 2;
    localparam int FLAG_V  = 1;
    localparam int FLAG_DZ = 0;
endpackage

// File: rtl/alu_seq_n_if.sv
// alu_seq_n_if: start/done request bundle of the sequential ALU.
// ALU_HI_RESULT_EN adds the result_hi response signal.
interface alu_seq_n_if #(parameter int WIDTH = 16);
    logic             start;
    logic [2:0]       opcode;
    logic             sgn;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;
    logic             done;
`ifdef ALU_HI_RESULT_EN
    logic [WIDTH-1:0] result_hi;
    modport master(output start, opcode, sgn, A, B, input result, flags, busy, done, result_hi);
    modport slave(input start, opcode, sgn, A, B, output result, flags, busy, done, result_hi);
`else
    modport master(output start, opcode, sgn, A, B, input result, flags, busy, done);
    modport slave(input start, opcode, sgn, A, B, output result, flags, busy, done);
`endif
endinterface

// File: rtl/seq_divider_n.sv
// seq_divider_n: unsigned restoring divider, one quotient bit per i_step after i_load.
module seq_divider_n #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);
    logic [WIDTH-1:0] r_quo, r_rem, r_div;
    logic [WIDTH:0]   w_trial, w_diff;
    // remainder stays below the divisor, so bit WIDTH of the difference is the borrow
    assign w_trial = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_div};
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (i_step) begin
            r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
            r_rem <= w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/alu_seq_n.sv
// alu_seq_n: sequential ALU executing one operation per start/done transaction.
// Optional feature macro ALU_HI_RESULT_EN adds result_hi (MUL high half, DIV remainder, REM quotient).
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    alu_seq_n_if.slave bus
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_op;
    logic r_sgn, r_busy, r_done;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, r_result;
    logic [3:0] r_flags, w_flags;
    logic w_accept, w_iter_in, w_na, w_nb, w_neg, w_dz, w_min_m1, w_v;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_mb, w_q, w_r, w_qs, w_rs, w_res;
    logic [WIDTH:0] w_add, w_sub, w_madd;
    logic [2*WIDTH-1:0] w_prod, w_sprod;
    assign w_accept  = r_state == S_IDLE && bus.start;
    assign w_iter_in = bus.opcode == OP_MUL || ((bus.opcode == OP_DIV || bus.opcode == OP_REM) && bus.B != '0);
    assign w_mag_a   = (bus.sgn && bus.A[M]) ? -bus.A : bus.A;
    assign w_mag_b   = (bus.sgn && bus.B[M]) ? -bus.B : bus.B;
    assign w_na      = r_sgn && r_a[M];
    assign w_nb      = r_sgn && r_b[M];
    assign w_neg     = w_na ^ w_nb;
    assign w_mb      = w_nb ? -r_b : r_b;
    assign w_madd    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, w_mb} : '0);
    assign w_add     = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub     = {1'b0, r_a} - {1'b0, r_b};
    assign w_prod    = {r_hi, r_lo};
    assign w_sprod   = w_neg ? -w_prod : w_prod;
    assign w_qs      = w_neg ? -w_q : w_q;
    assign w_rs      = w_na ? -w_r : w_r;
    assign w_dz      = (r_op == OP_DIV || r_op == OP_REM) && r_b == '0;
    assign w_min_m1  = r_sgn && r_a == {1'b1, {M{1'b0}}} && &r_b;
    seq_divider_n #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_accept),
        .i_step     (r_state == S_ITER),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quotient (w_q),
        .o_remainder(w_r)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !bus.start ? S_IDLE : w_iter_in ? S_ITER : S_FIN;
            S_ITER:  w_next = r_cnt == LAST ? S_FIN : S_ITER;
            default: w_next = S_IDLE;
        endcase
    end
    always_comb begin
        w_res = r_a ^ r_b;
        w_v   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_add[M:0];
                w_v   = r_sgn ? (r_a[M] == r_b[M] && w_add[M] != r_a[M]) : w_add[WIDTH];
            end
            OP_SUB: begin
                w_res = w_sub[M:0];
                w_v   = r_sgn ? (r_a[M] != r_b[M] && w_sub[M] != r_a[M]) : w_sub[WIDTH];
            end
            OP_MUL: begin
                w_res = w_sprod[M:0];
                w_v   = r_sgn ? !(&w_sprod[2*WIDTH-1:M] || ~|w_sprod[2*WIDTH-1:M]) : |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                w_res = w_dz ? '1 : w_qs;
                w_v   = w_min_m1;
            end
            OP_REM: begin
                w_res = w_dz ? r_a : w_rs;
                w_v   = w_min_m1;
            end
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            default: ;
        endcase
        w_flags          = '0;
        w_flags[FLAG_Z]  = w_res == '0;
        w_flags[FLAG_N]  = w_res[M];
        w_flags[FLAG_V]  = w_v;
        w_flags[FLAG_DZ] = w_dz;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_sgn    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= r_state == S_FIN;
            r_cnt  <= r_state == S_ITER ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_op   <= bus.opcode;
                r_sgn  <= bus.sgn;
                r_a    <= bus.A;
                r_b    <= bus.B;
                r_hi   <= '0;
                r_lo   <= w_mag_a;
                r_busy <= w_iter_in;
            end else if (r_state == S_ITER) begin
                {r_hi, r_lo} <= {w_madd, r_lo[M:1]};
            end
            if (r_state == S_FIN) begin
                r_result <= w_res;
                r_flags  <= w_flags;
                r_busy   <= 1'b0;
            end
        end
    end
    assign bus.result = r_result;
    assign bus.flags  = r_flags;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
`ifdef ALU_HI_RESULT_EN
    logic [WIDTH-1:0] r_res_hi, w_hi;
    assign w_hi = r_op == OP_MUL ? w_sprod[2*WIDTH-1:WIDTH] :
                  r_op == OP_DIV ? (w_dz ? r_a : w_rs) :
                  r_op == OP_REM ? (w_dz ? '1 : w_qs) : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_res_hi <= '0;
        else if (r_state == S_FIN) r_res_hi <= w_hi;
    end
    assign bus.result_hi = r_res_hi;
`endif
endmodule

// File: tb/tb_alu_seq_n.sv
// tb_alu_seq_n: directed vector table, multi-cycle corner sequences and random ops
// against an arithmetic reference model of the 16-bit sequential ALU.
module tb_alu_seq_n;
    import alu_pkg::*;
    logic clk, reset_n;
    int total, bad;
    alu_seq_n_if #(.WIDTH(16)) bus();
    alu_seq_n #(.WIDTH(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0]  op;
        logic        s;
        logic [15:0] a, b, res;
        logic [3:0]  fl;
    } vec_t;
    vec_t vt[16];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    function automatic void model(input logic [2:0] op, input logic s, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic [3:0] fl, output logic [15:0] hi);
        longint sa, sb, full, q, r, lo_lim, hi_lim;
        logic v, dz;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[15]) sa -= 65536;
        if (s && b[15]) sb -= 65536;
        lo_lim = s ? -32768 : 0;
        hi_lim = s ? 32767 : 65535;
        v = 1'b0; dz = 1'b0; hi = '0; res = '0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: begin
                full = op == OP_ADD ? sa + sb : op == OP_SUB ? sa - sb : sa * sb;
                res  = full[15:0];
                v    = full < lo_lim || full > hi_lim;
                if (op == OP_MUL) hi = full[31:16];
            end
            OP_DIV, OP_REM: begin
                if (b == 16'h0) begin
                    dz  = 1'b1;
                    res = op == OP_DIV ? 16'hFFFF : a;
                    hi  = op == OP_DIV ? a : 16'hFFFF;
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    v   = q > hi_lim;
                    res = op == OP_DIV ? q[15:0] : r[15:0];
                    hi  = op == OP_DIV ? r[15:0] : q[15:0];
                end
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            default: res = a ^ b;
        endcase
        fl = {res == 16'h0, res[15], v, dz};
    endfunction
    function automatic logic [15:0] rnd();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction
    task automatic run_op(input logic [2:0] op, input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [3:0] ef, input string nm, input bit poke);
        int n, lat;
        bit saw_busy;
        logic [15:0] mr, mh;
        logic [3:0] mf;
        model(op, s, a, b, mr, mf, mh);
        lat = (op == OP_MUL || ((op == OP_DIV || op == OP_REM) && b != 16'h0)) ? 18 : 2;
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.sgn = s; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.opcode = 3'($urandom); bus.sgn = 1'($urandom); bus.A = 16'($urandom); bus.B = 16'($urandom);
        n = 1;
        saw_busy = bus.busy;
        while (!bus.done && n < 40) begin
            bus.start = poke && n == 5;
            @(negedge clk);
            n++;
            saw_busy |= bus.busy;
        end
        bus.start = 1'b0;
        chk({nm, " latency"}, n, lat);
        chk({nm, " result"}, bus.result, er);
        chk({nm, " flags"}, bus.flags, ef);
        chk({nm, " busy seen"}, saw_busy, lat == 18);
        chk({nm, " busy in done"}, bus.busy, 0);
`ifdef ALU_HI_RESULT_EN
        chk({nm, " result_hi"}, bus.result_hi, mh);
`endif
        @(negedge clk);
        chk({nm, " done pulse"}, bus.done, 0);
        chk({nm, " result hold"}, bus.result, er);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n;
        bit seen;
        logic [2:0] op;
        logic s;
        logic [15:0] a, b, er, eh;
        logic [3:0] ef;
        total = 0; bad = 0;
        vt[0]  = '{OP_ADD, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110};
        vt[1]  = '{OP_MUL, 1'b1, 16'hFED4, 16'h00C8, 16'h15A0, 4'b0010};
        vt[2]  = '{OP_MUL, 1'b0, 16'hFED4, 16'h00C8, 16'h15A0, 4'b0010};
        vt[3]  = '{OP_DIV, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 4'b0100};
        vt[4]  = '{OP_REM, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 4'b0100};
        vt[5]  = '{OP_DIV, 1'b0, 16'd123,  16'h0000, 16'hFFFF, 4'b0101};
        vt[6]  = '{OP_REM, 1'b0, 16'd123,  16'h0000, 16'h007B, 4'b0001};
        vt[7]  = '{OP_DIV, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 4'b0110};
        vt[8]  = '{OP_REM, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 4'b1010};
        vt[9]  = '{OP_SUB, 1'b0, 16'd5,    16'd9,    16'hFFFC, 4'b0110};
        vt[10] = '{OP_SUB, 1'b1, 16'd5,    16'd9,    16'hFFFC, 4'b0100};
        vt[11] = '{OP_AND, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
        vt[12] = '{OP_XOR, 1'b1, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000};
        vt[13] = '{OP_OR,  1'b0, 16'h1234, 16'h8000, 16'h9234, 4'b0100};
        vt[14] = '{OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
        vt[15] = '{OP_MUL, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010};
        reset_n = 1'b0;
        bus.start = 1'b0; bus.opcode = '0; bus.sgn = 1'b0; bus.A = '0; bus.B = '0;
        @(negedge clk);
        chk("reset result", bus.result, 0);
        chk("reset flags", bus.flags, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++)
            run_op(vt[i].op, vt[i].s, vt[i].a, vt[i].b, vt[i].res, vt[i].fl, $sformatf("vec%0d", i), 1'b0);
        run_op(OP_MUL, 1'b1, 16'hFED4, 16'h00C8, 16'h15A0, 4'b0010, "mul poke", 1'b1);
        // reset in the middle of a multiply: outputs clear, no done follows
        run_op(OP_OR, 1'b0, 16'h1234, 16'h8000, 16'h9234, 4'b0100, "pre reset", 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.sgn = 1'b0; bus.A = 16'd300; bus.B = 16'd200;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset result", bus.result, 0);
        chk("midreset flags", bus.flags, 0);
        chk("midreset busy", bus.busy, 0);
        chk("midreset done", bus.done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen |= bus.done;
        end
        chk("midreset no done", seen, 0);
        run_op(OP_ADD, 1'b0, 16'd2, 16'd3, 16'd5, 4'b0000, "post reset add", 1'b0);
        // back-to-back with start held high: SUB then XOR accepted in the done cycle
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_SUB; bus.sgn = 1'b1; bus.A = 16'd5; bus.B = 16'd9;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b sub latency", n, 2);
        chk("b2b sub result", bus.result, 16'hFFFC);
        chk("b2b sub flags", bus.flags, 4'b0100);
        bus.opcode = OP_XOR; bus.A = 16'h1234; bus.B = 16'h00FF;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b done gap", n, 2);
        chk("b2b xor result", bus.result, 16'h12CB);
        chk("b2b xor flags", bus.flags, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom);
            s  = 1'($urandom);
            a  = rnd();
            b  = rnd();
            model(op, s, a, b, er, ef, eh);
            run_op(op, s, a, b, er, ef, $sformatf("rand%0d op%0d s%0d %h,%h", i, op, s, a, b), 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
